// File: rtl/shifter_pkg.sv
// shifter_pkg: resolution encodings, register addresses, per-mode plane counts/divisors and palette channel helper
package shifter_pkg;
  typedef enum logic [1:0] {RES_LOW = 2'd0, RES_MED = 2'd1, RES_MONO = 2'd2, RES_MONO_ALT = 2'd3} res_e;
  localparam logic [4:0] ADDR_PAL_BASE = 5'd0;
  localparam logic [4:0] ADDR_RES = 5'd16;
  localparam logic [2:0] PLANES_LOW = 3'd4;
  localparam logic [2:0] PLANES_MED = 3'd2;
  localparam logic [2:0] PLANES_MONO = 3'd1;
  localparam logic [2:0] DIV_LOW = 3'd4;
  localparam logic [2:0] DIV_MED = 3'd2;
  localparam logic [2:0] DIV_MONO = 3'd1;
  function automatic logic [2:0] mode_planes(input logic [1:0] m);
    return m == RES_LOW ? PLANES_LOW : m == RES_MED ? PLANES_MED : PLANES_MONO;
  endfunction
  function automatic logic [2:0] mode_div(input logic [1:0] m);
    return m == RES_LOW ? DIV_LOW : m == RES_MED ? DIV_MED : DIV_MONO;
  endfunction
  // Nibble bit 3 is the LSB of the output channel; the 3-bit palette never stores it, so it reads as 0 there.
  function automatic logic [3:0] pal_chan(input logic [3:0] n);
    return {n[2:0], n[3]};
  endfunction
endpackage

// File: rtl/shifter_palette.sv
// shifter_palette: 16-entry colour palette plus resolution register with CPU read mux
// Ports: i_clk/i_rst (async high) clock and reset; i_we/i_addr/i_wdata CPU write; o_rdata CPU read data;
//        i_idx/o_col pixel colour lookup; o_pal0 border colour; o_mode resolution mode.
// Macro SHIFTER_STE_PALETTE_EN keeps all 4 bits per channel; otherwise only 3 bits per channel are stored.
module shifter_palette
  import shifter_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [11:0] i_wdata,
  output logic [15:0] o_rdata,
  input  logic [3:0]  i_idx,
  output logic [11:0] o_col,
  output logic [11:0] o_pal0,
  output logic [1:0]  o_mode
);
`ifdef SHIFTER_STE_PALETTE_EN
  localparam logic [11:0] PAL_MASK = 12'hFFF;
`else
  localparam logic [11:0] PAL_MASK = 12'h777;
`endif
  logic [11:0] r_pal [16];
  logic [1:0]  r_mode;
  logic        w_pal_sel;
  assign w_pal_sel = i_addr[4] == ADDR_PAL_BASE[4];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_pal <= '{default: '0};
      r_mode <= RES_LOW;
    end else if (i_we) begin
      if (w_pal_sel) r_pal[i_addr[3:0]] <= i_wdata & PAL_MASK;
      else if (i_addr == ADDR_RES) r_mode <= i_wdata[9:8];
    end
  assign o_rdata = w_pal_sel ? {4'd0, r_pal[i_addr[3:0]]} : i_addr == ADDR_RES ? {6'd0, r_mode, 8'd0} : 16'd0;
  assign o_col = r_pal[i_idx];
  assign o_pal0 = r_pal[0];
  assign o_mode = r_mode;
endmodule

// File: rtl/shifter.sv
// shifter: bit-plane video shifter with palette lookup, three resolutions and registered RGB output
// Ports: CLOCK_32 clock; reset async high; de display enable; cs/rw/addr/data_in CPU access, data_out/oe read side;
//        load video-word strobe (data_in carries the word); r/g/b 4-bit pixel colour.
// Macro SHIFTER_STE_PALETTE_EN selects the 4-bit-per-channel palette (default: 3-bit).
module shifter
  import shifter_pkg::*;
(
  input  logic        CLOCK_32,
  input  logic        reset,
  input  logic        de,
  input  logic        cs,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        rw,
  input  logic [4:0]  addr,
  output logic        oe,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);
  logic        w_we, w_res_wr, w_load_edge, w_last, w_xfer, w_tick, w_mono_on;
  logic [15:0] w_rdata;
  logic [11:0] w_col, w_pal0, w_src, w_rgb;
  logic [1:0]  w_mode;
  logic [2:0]  w_planes, w_div;
  logic [3:0]  w_idx;
  logic [15:0] w_sh_in [4];
  logic        r_load_d;
  logic [1:0]  r_plane_cnt, r_div;
  logic [15:0] r_buf [3];
  logic [15:0] r_shift [4];

  shifter_palette u_pal (
    .i_clk(CLOCK_32), .i_rst(reset), .i_we(w_we), .i_addr(addr), .i_wdata(data_in[11:0]),
    .o_rdata(w_rdata), .i_idx(w_idx), .o_col(w_col), .o_pal0(w_pal0), .o_mode(w_mode)
  );

  assign oe = cs & rw;
  assign w_we = cs & ~rw;
  assign data_out = oe ? w_rdata : 16'd0;
  assign w_res_wr = w_we && addr == ADDR_RES;
  assign w_load_edge = load & ~r_load_d;
  assign w_planes = mode_planes(w_mode);
  assign w_div = mode_div(w_mode);
  assign w_last = r_plane_cnt == 2'(w_planes - 3'd1);
  assign w_xfer = w_load_edge & w_last;
  assign w_tick = r_div == 2'(w_div - 3'd1);
  // On a transfer the plane being loaded comes straight from data_in; planes beyond the count are zero.
  assign w_sh_in[0] = r_plane_cnt == 2'd0 ? data_in : r_buf[0];
  assign w_sh_in[1] = r_plane_cnt == 2'd1 ? data_in : r_plane_cnt > 2'd1 ? r_buf[1] : 16'd0;
  assign w_sh_in[2] = r_plane_cnt == 2'd2 ? data_in : r_plane_cnt == 2'd3 ? r_buf[2] : 16'd0;
  assign w_sh_in[3] = r_plane_cnt == 2'd3 ? data_in : 16'd0;
  assign w_idx = {r_shift[3][15], r_shift[2][15], r_shift[1][15], r_shift[0][15]};
  assign w_src = de ? w_col : w_pal0;
  assign w_mono_on = de & ~(r_shift[0][15] ^ w_pal0[0]);
  // Modes 2 and 3 are both monochrome.
  assign w_rgb = w_mode[1] ? {12{w_mono_on}} : {pal_chan(w_src[11:8]), pal_chan(w_src[7:4]), pal_chan(w_src[3:0])};

  always_ff @(posedge CLOCK_32 or posedge reset)
    if (reset) begin
      r_load_d <= 1'b0;
      r_plane_cnt <= 2'd0;
      r_div <= 2'd0;
      r_buf <= '{default: '0};
      r_shift <= '{default: '0};
      {r, g, b} <= 12'd0;
    end else begin
      r_load_d <= load;
      for (int p = 0; p < 3; p++) if (w_load_edge && r_plane_cnt == 2'(p)) r_buf[p] <= data_in;
      r_plane_cnt <= w_res_wr ? 2'd0 : !w_load_edge ? r_plane_cnt : w_last ? 2'd0 : r_plane_cnt + 2'd1;
      r_div <= (w_xfer || w_tick) ? 2'd0 : r_div + 2'd1;
      for (int p = 0; p < 4; p++) r_shift[p] <= w_xfer ? w_sh_in[p] : w_tick ? {r_shift[p][14:0], 1'b0} : r_shift[p];
      {r, g, b} <= w_rgb;
    end
endmodule

// File: tb/tb_shifter.sv
// tb_shifter: directed bench for shifter with a pixel scoreboard
`timescale 1ns/1ps
module tb_shifter;
  logic        clk = 1'b0, reset = 1'b1, de = 1'b0, cs = 1'b0, load = 1'b0, rw = 1'b0;
  logic [15:0] data_in = 16'd0, data_out;
  logic [4:0]  addr = 5'd0;
  logic        oe;
  logic [3:0]  r, g, b;
  int          ntests = 0, nfail = 0;
  logic [11:0] pal_m [16];
  logic [1:0]  res_m;
  logic [11:0] sb [$];

  shifter dut (
    .CLOCK_32(clk), .reset(reset), .de(de), .cs(cs), .load(load), .data_in(data_in),
    .data_out(data_out), .rw(rw), .addr(addr), .oe(oe), .r(r), .g(g), .b(b)
  );

  always #15.625 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] chan(input logic [3:0] n);
`ifdef SHIFTER_STE_PALETTE_EN
    return {n[2:0], n[3]};
`else
    return {n[2:0], 1'b0};
`endif
  endfunction

  function automatic logic [11:0] rb(input logic [11:0] w);
`ifdef SHIFTER_STE_PALETTE_EN
    return w;
`else
    return w & 12'h777;
`endif
  endfunction

  function automatic logic [11:0] colr(input logic [11:0] w);
    return {chan(w[11:8]), chan(w[7:4]), chan(w[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_wr(input logic [4:0] a, input logic [15:0] d);
    if (a < 5'd16) pal_m[a[3:0]] = d[11:0];
    else if (a == 5'd16) res_m = d[9:8];
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd(input string tag, input logic [4:0] a);
    logic [15:0] e;
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; addr = a;
    #1;
    e = a < 5'd16 ? {4'd0, rb(pal_m[a[3:0]])} : a == 5'd16 ? {6'd0, res_m, 8'd0} : 16'd0;
    chk(tag, data_out, e);
    chk({tag, "_oe"}, {15'd0, oe}, 16'd1);
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic ld(input logic [15:0] d);
    @(negedge clk);
    load = 1'b1; data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic ldw(input logic [15:0] d, input logic [4:0] a);
    @(negedge clk);
    load = 1'b1; data_in = d; cs = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    load = 1'b0; cs = 1'b0;
    model_wr(a, d);
  endtask

  task automatic push(input logic [11:0] v, input int n);
    repeat (n) sb.push_back(v);
  endtask

  task automatic drain(input string tag);
    logic [11:0] e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk(tag, {4'd0, r, g, b}, {4'd0, e});
    end
  endtask

  initial begin
    pal_m = '{default: '0};
    res_m = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {4'd0, r, g, b}, 16'd0);
    reset = 1'b0;
    chk("idle_dout", data_out, 16'd0);
    chk("idle_oe", {15'd0, oe}, 16'd0);
    rd("rst_pal0", 5'd0);
    rd("rst_res", 5'd16);
    wr(5'd1, 16'h0F00);
    rd("pal1", 5'd1);
    wr(5'd20, 16'hFFFF);
    rd("unused20", 5'd20);
    wr(5'd16, 16'hFFFF);
    rd("res3", 5'd16);
    wr(5'd2, 16'hFFFF);
    rd("pal2_mask", 5'd2);
    // low resolution: one lit pixel then border-free background
    wr(5'd0, 16'h0123);
    wr(5'd16, 16'h0000);
    de = 1'b1;
    ld(16'h8000); ld(16'h0000); ld(16'h0000); ld(16'h0000);
    push(colr(pal_m[1]), 4);
    push(colr(pal_m[0]), 8);
    drain("low_pix");
    // medium resolution with a palette write on the same edge as the first load
    wr(5'd16, 16'h0100);
    ldw(16'hC0F5, 5'd3);
    ld(16'hC000);
    push(colr(pal_m[3]), 4);
    push(colr(pal_m[0]), 4);
    drain("med_pix");
    rd("pal3_simul", 5'd3);
    // monochrome
    wr(5'd0, 16'h0000);
    wr(5'd16, 16'h0200);
    ld(16'hAAAA);
    for (int i = 0; i < 16; i++) push(i % 2 == 0 ? 12'h000 : 12'hFFF, 1);
    push(12'hFFF, 2);
    drain("mono_pix");
    de = 1'b0;
    push(12'h000, 3);
    drain("mono_border");
    // border during shifting in low resolution
    wr(5'd16, 16'h0000);
    wr(5'd0, 16'h0007);
    ld(16'hFFFF); ld(16'hFFFF); ld(16'hFFFF); ld(16'hFFFF);
    push(colr(pal_m[0]), 8);
    drain("border_pix");
    chk("border_b", {12'd0, b}, 16'h000E);
    // reset in the middle of a plane load
    ld(16'h8000); ld(16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("midrst_rgb", {4'd0, r, g, b}, 16'd0);
    chk("midrst_dout", data_out, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    pal_m = '{default: '0};
    res_m = 2'd0;
    rd("midrst_pal0", 5'd0);
    wr(5'd1, 16'h0F00);
    wr(5'd0, 16'h0123);
    de = 1'b1;
    ld(16'h8000); ld(16'h0000); ld(16'h0000); ld(16'h0000);
    push(colr(pal_m[1]), 4);
    push(colr(pal_m[0]), 4);
    drain("after_rst_pix");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/shifter.md
SHIFTER -- requirements
Module: shifter

Interface
REQ-001 The block SHALL have these ports: CLOCK_32  in  1  sole clock, 32 MHz, all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 de  in  1  display enable; high = active picture, low = border.
REQ-004 cs  in  1  register select, active-high.
REQ-005 load  in  1  video-word load strobe, active-high.
REQ-006 data_in  in  16  CPU write data / video RAM word.
REQ-007 data_out  out  16  register read data.
REQ-008 rw  in  1  1 = CPU read, 0 = CPU write.
REQ-009 addr  in  5  word address: 0-15 palette, 16 resolution, 17-31 unused.
REQ-010 oe  out  1  data_out drive enable.
REQ-011 r, g, b  out  4 each  pixel colour.

Function
REQ-012 Write: on a clock edge with cs=1 and rw=0, the addressed register SHALL load data_in; writes to addresses 17-31 are ignored.
REQ-013 Palette word layout: [11:8] R, [7:4] G, [3:0] B; each nibble n drives its channel as {n[2:0], n[3]}; bits [15:12] read back 0.
REQ-014 Resolution register: bits [9:8] hold the mode (0 low: 4 planes, pixel every 4 clocks; 1 medium: 2 planes, every 2; 2 mono: 1 plane, every clock); 3 behaves as 2 but reads back 3; other bits read 0.
REQ-015 Read: oe = cs & rw (combinational); data_out = addressed register (0 for unused addresses), combinational; data_out = 0 when oe=0.
REQ-016 Load: each 0->1 transition of load (sampled on the clock) SHALL store data_in into plane buffer[plane_cnt] and increment plane_cnt, wrapping at planes-1.
REQ-017 On the load that completes the last plane, all buffers SHALL transfer to the shift registers on the same edge, resetting the pixel divider and pixel count to 0.
REQ-018 Shift registers output MSB first; the pixel index = {plane3, plane2, plane1, plane0} bits (unused planes 0); shift one bit per pixel period; after 16 pixels without a new transfer, zeros shift in (index 0).
REQ-019 Colour output SHALL be registered: first pixel of a transfer appears on r/g/b one clock after the transfer edge.
REQ-020 With de=0, r/g/b SHALL show palette 0 (border); with de=1, palette[index].
REQ-021 Mono mode: r=g=b=4'hF when (pixel XOR palette0[0])=0, else 4'h0; de=0 shows 4'h0.
REQ-022 A resolution write resets plane_cnt to 0; shift contents are kept.
REQ-023 A simultaneous load edge and CPU write SHALL both take effect.

Reset
REQ-024 On reset: palette = 0, resolution = 0, buffers/shift registers = 0, plane_cnt = 0, divider = 0, r/g/b = 0; oe and data_out follow REQ-015 combinationally.
REQ-025 Reset mid-line SHALL abort any partial plane load; operation resumes at the first load after release.

Configuration
REQ-026 Macro SHIFTER_STE_PALETTE_EN defined: 4-bit channels as in REQ-013.
REQ-027 Not defined: STF palette; only nibble bits [2:0] are stored; nibble bit 3 reads back 0; channel output = {n[2:0], 1'b0}.

Structure
REQ-028 Package shifter_pkg SHALL hold the resolution encodings, address constants (palette base 0, resolution 16) and per-mode plane counts and pixel divisors.
REQ-029 One sub-module, shifter_palette (16-entry register file plus resolution register, read mux), SHALL be used; shift/pixel logic stays in shifter.

Verification
REQ-030 Reset, then read addr 0 and addr 16 -> data_out 0x0000, oe 1; r/g/b 0.
REQ-031 Write 0x0F00 to addr 1, read back -> 0x0F00 (STE build) or 0x0700 (STF build).
REQ-032 Low res: palette 1 = 0x0F00, loads 0x8000,0,0,0, de=1 -> r=4'hF for 4 clocks starting 1 clock after the 4th load, then palette 0 colour.
REQ-033 Medium res: loads 0xC000, 0xC000 -> index 3 for 2 pixels (4 clocks), then index 0.
REQ-034 Mono: palette 0 = 0x0000, load 0xAAAA -> r/g/b alternate 0x0/0xF each clock for 16 clocks.
REQ-035 de=0 during shifting with palette 0 = 0x0007 -> b=4'hE (STE) / 4'hE (STF); assert reset mid-load -> next 4 loads produce correct picture.
